// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption: one inverse round per clock over a shared datapath.
// Latency: block accepted at E0, plaintext and one-cycle done strobe registered at E10.
// Backpressure: none; rx_state while busy (including the E10 edge) is silently dropped.

module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Inverse S-box as a flat byte table, entry 0 in the leftmost byte
    localparam logic [0:2047] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign out_byte = TBL[{in_byte, 3'b000} +: 8];
endmodule

module aes_decrypt_iterative (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] data,
    input  logic         rx_state,
    input  logic [0:127] key_0,
    input  logic [0:127] key_1,
    input  logic [0:127] key_2,
    input  logic [0:127] key_3,
    input  logic [0:127] key_4,
    input  logic [0:127] key_5,
    input  logic [0:127] key_6,
    input  logic [0:127] key_7,
    input  logic [0:127] key_8,
    input  logic [0:127] key_9,
    input  logic [0:127] key_10,
    output logic [0:127] decrypted_data,
    output logic         decrypted_data_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t       state_q, state_d;
    logic [0:127] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] dout_q, dout_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic [0:127] sr, sb, rkey, round_out, final_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r positions; byte index is row + 4*column
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(r+4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
        return o;
    endfunction

    // Column times {0e,0b,0d,09} built from x2/x4/x8 xtime products
    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a   [4];
        logic [7:0]   x1  [4];
        logic [7:0]   x2  [4];
        logic [7:0]   x4  [4];
        logic [7:0]   x8  [4];
        logic [7:0]   m9  [4];
        logic [7:0]   mb  [4];
        logic [7:0]   md  [4];
        logic [7:0]   me  [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[8*(r+4*c) +: 8];
                x1[r] = a[r];
                x2[r] = xtime(x1[r]);
                x4[r] = xtime(x2[r]);
                x8[r] = xtime(x4[r]);
                m9[r] = x8[r] ^ x1[r];
                mb[r] = x8[r] ^ x2[r] ^ x1[r];
                md[r] = x8[r] ^ x4[r] ^ x1[r];
                me[r] = x8[r] ^ x4[r] ^ x2[r];
            end
            o[8*(4*c)   +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[8*(4*c+1) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[8*(4*c+2) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[8*(4*c+3) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    assign sr = inv_shift_rows(st_q);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (sr[8*g +: 8]),
            .out_byte (sb[8*g +: 8])
        );
    end

    // Round key select by round counter; key_10 only feeds the load whitening
    always_comb begin
        rkey = key_0;
        case (rnd_q)
            4'd1:    rkey = key_1;
            4'd2:    rkey = key_2;
            4'd3:    rkey = key_3;
            4'd4:    rkey = key_4;
            4'd5:    rkey = key_5;
            4'd6:    rkey = key_6;
            4'd7:    rkey = key_7;
            4'd8:    rkey = key_8;
            4'd9:    rkey = key_9;
            4'd10:   rkey = key_10;
            default: rkey = key_0;
        endcase
    end

    assign round_out = inv_mix_columns(sb ^ rkey);
    assign final_out = sb ^ key_0;

    // Next-state logic: load, nine full inverse rounds, then the final round without InvMixColumns
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_state && !busy_q) begin
                    st_d    = data ^ key_10;
                    rnd_d   = 4'd9;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = round_out;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                dout_d  = final_out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any block in flight without a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign decrypted_data       = dout_q;
    assign decrypted_data_state = done_q;
    assign busy                 = busy_q;
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: known-answer vectors, busy rejection, reset and random round trips.
// Expected plaintexts come from constants or a forward AES-128 model built from GF(2^8) arithmetic.
// A monitor checks every cycle: strobe payload and timing, held output value and busy.

module tb_aes_decrypt_iterative;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:127] data;
    logic         rx_state;
    logic [0:127] rk [11];
    logic [0:127] decrypted_data;
    logic         decrypted_data_state;
    logic         busy;

    typedef struct {
        logic [0:127] pt;
        int           cyc;
    } exp_t;

    exp_t         sb_q [$];
    logic [0:127] held = '0;
    logic [7:0]   sbox [256];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iterative dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .data                 (data),
        .rx_state             (rx_state),
        .key_0                (rk[0]),
        .key_1                (rk[1]),
        .key_2                (rk[2]),
        .key_3                (rk[3]),
        .key_4                (rk[4]),
        .key_5                (rk[5]),
        .key_6                (rk[6]),
        .key_7                (rk[7]),
        .key_8                (rk[8]),
        .key_9                (rk[9]),
        .key_10               (rk[10]),
        .decrypted_data       (decrypted_data),
        .decrypted_data_state (decrypted_data_state),
        .busy                 (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher with the current round keys
    function automatic logic [0:127] encrypt(input logic [0:127] pt);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) b[i] = pt[8*i +: 8] ^ rk[0][8*i +: 8];
        for (int rr = 1; rr <= 10; rr++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[b[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = b[r + 4*((c + r) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (rr < 10) begin
                    b[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    b[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) b[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ rk[rr][8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = b[i];
        return o;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input logic [0:127] ct, input logic [0:127] pt);
        data     = ct;
        rx_state = 1'b1;
        @(posedge clk);
        #1;
        rx_state = 1'b0;
        sb_q.push_back('{pt: pt, cyc: cyc - 1});
    endtask

    // Ten edges E1..E10 of a block in flight, with optional stray pulses at edges p1/p2
    task automatic flight(input int p1, input int p2, input int extra);
        for (int e = 1; e <= 10; e++) begin
            if (e == p1 || e == p2) begin
                data     = {$urandom, $urandom, $urandom, $urandom};
                rx_state = 1'b1;
            end
            @(posedge clk);
            #1;
            rx_state = 1'b0;
        end
        repeat (extra) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (decrypted_data_state) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got data %h with no block outstanding", decrypted_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("plaintext", decrypted_data, e.pt);
                        check("strobe_cycle", 128'(cyc), 128'(e.cyc + 11));
                        check("busy_at_strobe", busy, 0);
                        held = e.pt;
                    end
                end else begin
                    check("held_data", decrypted_data, held);
                    check("busy", busy, (sb_q.size() != 0) ? 1 : 0);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n    = 1'b0;
        rx_state = 1'b0;
        data     = '0;
        for (int i = 0; i < 11; i++) rk[i] = '0;
        build_sbox();
        #12;
        check("reset_data", decrypted_data, 0);
        check("reset_strobe", decrypted_data_state, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1 and Appendix B
        expand_key(C1_KEY);
        send(C1_CT, C1_PT);
        flight(0, 0, 2);
        expand_key(B_KEY);
        send(B_CT, B_PT);
        flight(0, 0, 3);

        // stray requests at E4 and at the strobe-raising edge E10 are dropped
        expand_key(C1_KEY);
        send(C1_CT, C1_PT);
        flight(4, 10, 4);

        // back-to-back: second block accepted on the edge after the strobe edge
        send(C1_CT, C1_PT);
        flight(0, 0, 0);
        expand_key(B_KEY);
        send(B_CT, B_PT);
        flight(0, 0, 2);

        // reset mid-block at E5
        expand_key(C1_KEY);
        send(C1_CT, C1_PT);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        held = '0;
        #1;
        check("midreset_data", decrypted_data, 0);
        check("midreset_strobe", decrypted_data_state, 0);
        check("midreset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(C1_CT, C1_PT);
        flight(0, 0, 1);

        // random round trips through the forward model
        for (int n = 0; n < 100; n++) begin
            logic [0:127] key;
            logic [0:127] pt;
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            send(encrypt(pt), pt);
            flight(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0, 0, int'($urandom_range(0, 2)));
        end

        repeat (15) @(posedge clk);
        #1;
        check("outstanding_blocks", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
